branch_target_predictor: RTL and testbench
==========================================

# branch_target_predictor

Parametrised branch/jump target predictor for the 5-stage MIPS pipeline, replacing the single-entry static jump predictor in fetch. Holds a direct-mapped table of ENTRIES tagged entries, each with a branch target and a 2-bit saturating direction counter. Fetch looks up the current PC combinationally and receives the next-PC prediction. Decode writes back resolved outcomes one cycle per update. A saturating mispredict counter is exported for debug.

## Interface
- ENTRIES, 16: table depth; power of two, minimum 2. IDX_W = log2(ENTRIES).
- TAG_W, 8: tag bits stored per entry; IDX_W+2+TAG_W ≤ 32.
- MISS_W, 16: width of the mispredict counter.
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; clears the table and the counter.
- LookupPC  in  32  fetch-stage PC.
- PredHit  out  1  a valid entry matches LookupPC (index and tag).
- PredTaken  out  1  PredHit and counter MSB = 1.
- PredTarget  out  32  stored target if PredTaken, else LookupPC+4.
- UpdValid  in  1  decode resolved a branch or jump this cycle.
- UpdPC  in  32  PC of the resolved instruction.
- UpdTaken  in  1  actual direction.
- UpdTarget  in  32  actual taken target; ignored when UpdTaken = 0.
- Invalidate  in  1  synchronous clear of all valid bits.
- MissCount  out  MISS_W  saturating count of mispredicted updates.

## Operation
- Index = PC[IDX_W+1:2]. Tag = PC[IDX_W+TAG_W+1:IDX_W+2]. PC[1:0] are ignored.
- Each entry holds: valid (1 bit), tag (TAG_W bits), target (32 bits), ctr (2 bits).
- Counter states: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
- Lookup is purely combinational from the table contents as of the last edge. PC+4 is computed modulo 2^32.
- Update, evaluated when UpdValid = 1:
  - Hit (valid and tag match at the UpdPC index):
    - ctr increments saturating at 11 if UpdTaken; otherwise decrements saturating at 00.
    - If UpdTaken, target ← UpdTarget.
  - Miss with UpdTaken = 1: allocate by overwriting the entry at that index. Set valid = 1, tag = UpdPC tag, target = UpdTarget, ctr = 10.
  - Miss with UpdTaken = 0: no table change.
- Mispredict is judged against the pre-update table state for UpdPC. It is true if:
  - the predicted direction ≠ UpdTaken, or
  - UpdTaken = 1 and PredTarget-equivalent ≠ UpdTarget.
  - A miss with UpdTaken = 0 is a correct prediction.
- MissCount increments on each mispredicted update and saturates at all-ones.
- Invalidate = 1: all valid bits ← 0 at the edge. Targets, ctrs and MissCount are unchanged.
- Invalidate and UpdValid in the same cycle: Invalidate wins and the update is dropped. MissCount still counts that update if it was mispredicted.

## Timing
- Lookup latency is 0 cycles (combinational). Update is visible to a lookup on the cycle after the edge.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update contents. There is no bypass.
- Back-to-back updates to the same entry on consecutive cycles each apply in order.
- Reset asserted, asynchronously: all valid bits = 0, all ctrs = 01, all targets = 0, MissCount = 0.
- Outputs while or after Reset: PredHit = 0, PredTaken = 0, PredTarget = LookupPC+4, MissCount = 0.
- Reset mid-update: the update is lost and the table is cleared.
- Aliasing: two PCs with equal index but different tags evict each other. There is no associativity.

## Test plan
- **Reset state:** assert Reset, release, LookupPC = 0x0000_0040 → PredHit = 0, PredTaken = 0, PredTarget = 0x0000_0044, MissCount = 0.
- **Allocation:** UpdValid with UpdPC = 0x40, UpdTaken = 1, UpdTarget = 0x100. Next cycle, lookup 0x40 → PredHit = 1, PredTaken = 1, PredTarget = 0x100, MissCount = 1.
- **Hysteresis:** from ctr 10, apply two not-taken updates → after the first, PredTaken = 0 (ctr 01); after the second, ctr 00. One taken update → still not taken (01); a second → taken (10). Separately, from 10 apply three taken updates → ctr saturates at 11.
- **Aliasing (ENTRIES = 16, TAG_W = 8):** allocate 0x40, then allocate 0x80 (same index, different tag) → lookup 0x40 gives PredHit = 0 and PredTarget = 0x44; lookup 0x80 hits.
- **Same-cycle update and lookup:** on the same cycle as an update to 0x40 with a new target 0x200, lookup 0x40 returns the old target 0x100; the next cycle returns 0x200.
- **Invalidate, saturation and async reset:**
  - Invalidate together with an update → no entry is valid afterwards.
  - With MISS_W = 2, four mispredicted updates → MissCount = 3.
  - Reset pulse between clock edges → outputs return to reset values immediately.

Source files
------------

// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped branch target predictor with 2-bit direction counters
// Fetch lookup is combinational; decode updates are applied at the rising edge.
module branch_target_predictor #(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int MISS_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [31:0]       LookupPC,
    output logic              PredHit,
    output logic              PredTaken,
    output logic [31:0]       PredTarget,
    input  logic              UpdValid,
    input  logic [31:0]       UpdPC,
    input  logic              UpdTaken,
    input  logic [31:0]       UpdTarget,
    input  logic              Invalidate,
    output logic [MISS_W-1:0] MissCount
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] validQ;
    logic [TAG_W-1:0]   tagQ    [ENTRIES];
    logic [31:0]        targetQ [ENTRIES];
    logic [1:0]         ctrQ    [ENTRIES];
    logic [MISS_W-1:0]  missCountQ;

    logic [IDX_W-1:0]   lookupIdx;
    logic [TAG_W-1:0]   lookupTag;
    logic [IDX_W-1:0]   updIdx;
    logic [TAG_W-1:0]   updTag;
    logic               updHit;
    logic               updPredTaken;
    logic [31:0]        updPredTarget;
    logic               updMispredict;
    logic [1:0]         updNextCtr;

    assign lookupIdx = LookupPC[IDX_W+1:2];
    assign lookupTag = LookupPC[IDX_W+TAG_W+1:IDX_W+2];
    assign updIdx    = UpdPC[IDX_W+1:2];
    assign updTag    = UpdPC[IDX_W+TAG_W+1:IDX_W+2];

    always_comb begin
        PredHit    = validQ[lookupIdx] && (tagQ[lookupIdx] == lookupTag);
        PredTaken  = PredHit && ctrQ[lookupIdx][1];
        PredTarget = PredTaken ? targetQ[lookupIdx] : LookupPC + 32'd4;
    end

    // The update path re-runs the lookup on UpdPC against the pre-edge table to judge the prediction.
    always_comb begin
        updHit        = validQ[updIdx] && (tagQ[updIdx] == updTag);
        updPredTaken  = updHit && ctrQ[updIdx][1];
        updPredTarget = updPredTaken ? targetQ[updIdx] : UpdPC + 32'd4;
        updMispredict = (updPredTaken != UpdTaken) ||
                        (UpdTaken && (updPredTarget != UpdTarget));
        updNextCtr    = ctrQ[updIdx];
        if (UpdTaken) begin
            if (ctrQ[updIdx] != 2'b11) begin
                updNextCtr = ctrQ[updIdx] + 2'd1;
            end
        end else begin
            if (ctrQ[updIdx] != 2'b00) begin
                updNextCtr = ctrQ[updIdx] - 2'd1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            validQ     <= '0;
            missCountQ <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tagQ[i]    <= '0;
                targetQ[i] <= '0;
                ctrQ[i]    <= 2'b01;
            end
        end else begin
            // A dropped update (Invalidate) is still scored.
            if (UpdValid && updMispredict && (missCountQ != '1)) begin
                missCountQ <= missCountQ + {{(MISS_W-1){1'b0}}, 1'b1};
            end
            if (Invalidate) begin
                validQ <= '0;
            end else if (UpdValid) begin
                if (updHit) begin
                    ctrQ[updIdx] <= updNextCtr;
                    if (UpdTaken) begin
                        targetQ[updIdx] <= UpdTarget;
                    end
                end else if (UpdTaken) begin
                    validQ[updIdx]  <= 1'b1;
                    tagQ[updIdx]    <= updTag;
                    targetQ[updIdx] <= UpdTarget;
                    ctrQ[updIdx]    <= 2'b10;
                end
            end
        end
    end

    assign MissCount = missCountQ;

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb/tb_branch_target_predictor.sv - directed self-checking bench for branch_target_predictor
module tb_branch_target_predictor;

    logic        Clk;
    logic        Reset;
    logic [31:0] LookupPC;
    logic        UpdValid;
    logic [31:0] UpdPC;
    logic        UpdTaken;
    logic [31:0] UpdTarget;
    logic        Invalidate;

    logic        PredHit,    satHit;
    logic        PredTaken,  satTaken;
    logic [31:0] PredTarget, satTarget;
    logic [15:0] MissCount;
    logic [1:0]  satMissCount;

    int assertCount = 0;
    int failCount   = 0;

    branch_target_predictor #(.ENTRIES(16), .TAG_W(8), .MISS_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .LookupPC(LookupPC),
        .PredHit(PredHit), .PredTaken(PredTaken), .PredTarget(PredTarget),
        .UpdValid(UpdValid), .UpdPC(UpdPC), .UpdTaken(UpdTaken), .UpdTarget(UpdTarget),
        .Invalidate(Invalidate), .MissCount(MissCount)
    );

    branch_target_predictor #(.ENTRIES(16), .TAG_W(8), .MISS_W(2)) dutSat (
        .Clk(Clk), .Reset(Reset), .LookupPC(LookupPC),
        .PredHit(satHit), .PredTaken(satTaken), .PredTarget(satTarget),
        .UpdValid(UpdValid), .UpdPC(UpdPC), .UpdTaken(UpdTaken), .UpdTarget(UpdTarget),
        .Invalidate(Invalidate), .MissCount(satMissCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc);
        LookupPC = pc;
        #1;
    endtask

    task automatic update(input logic [31:0] pc, input logic taken, input logic [31:0] target);
        UpdValid  = 1'b1;
        UpdPC     = pc;
        UpdTaken  = taken;
        UpdTarget = target;
        tick();
        UpdValid  = 1'b0;
        #1;
    endtask

    initial begin
        Reset = 1'b1; LookupPC = 32'h40; UpdValid = 1'b0; UpdPC = '0;
        UpdTaken = 1'b0; UpdTarget = '0; Invalidate = 1'b0;
        #12 Reset = 1'b0;
        #1;

        checkValue("rst_hit",    32'(PredHit),   32'd0);
        checkValue("rst_taken",  32'(PredTaken), 32'd0);
        checkValue("rst_target", PredTarget,     32'h44);
        checkValue("rst_miss",   32'(MissCount), 32'd0);

        // Allocate 0x40 -> 0x100; pre-update miss but taken counts as mispredict
        update(32'h40, 1'b1, 32'h100);
        lookup(32'h40);
        checkValue("alloc_hit",    32'(PredHit),   32'd1);
        checkValue("alloc_taken",  32'(PredTaken), 32'd1);
        checkValue("alloc_target", PredTarget,     32'h100);
        checkValue("alloc_miss",   32'(MissCount), 32'd1);

        // Hysteresis: 10 -> 01 -> 00 -> 01 -> 10
        update(32'h40, 1'b0, 32'h0);
        checkValue("hys_nt1_taken",  32'(PredTaken), 32'd0);
        checkValue("hys_nt1_hit",    32'(PredHit),   32'd1);
        checkValue("hys_nt1_target", PredTarget,     32'h44);
        update(32'h40, 1'b0, 32'h0);
        checkValue("hys_nt2_taken",  32'(PredTaken), 32'd0);
        checkValue("hys_nt2_miss",   32'(MissCount), 32'd2);
        update(32'h40, 1'b1, 32'h100);
        checkValue("hys_t1_taken",   32'(PredTaken), 32'd0);
        update(32'h40, 1'b1, 32'h100);
        checkValue("hys_t2_taken",   32'(PredTaken), 32'd1);
        checkValue("hys_t2_target",  PredTarget,     32'h100);
        checkValue("hys_miss",       32'(MissCount), 32'd4);
        checkValue("sat_miss",       32'(satMissCount), 32'd3);

        // Three taken updates saturate at 11, so one not-taken leaves it taken
        for (int i = 0; i < 3; i++) update(32'h40, 1'b1, 32'h100);
        checkValue("ctr_sat_taken",  32'(PredTaken), 32'd1);
        checkValue("ctr_sat_miss",   32'(MissCount), 32'd4);
        update(32'h40, 1'b0, 32'h0);
        checkValue("ctr_sat_nt",     32'(PredTaken), 32'd1);
        checkValue("ctr_sat_nt_miss",32'(MissCount), 32'd5);
        update(32'h40, 1'b1, 32'h100);
        checkValue("ctr_restore_miss", 32'(MissCount), 32'd5);

        // Same-cycle update and lookup: no bypass
        UpdValid = 1'b1; UpdPC = 32'h40; UpdTaken = 1'b1; UpdTarget = 32'h200;
        #1;
        checkValue("same_old_target", PredTarget, 32'h100);
        tick();
        UpdValid = 1'b0;
        #1;
        checkValue("same_new_target", PredTarget, 32'h200);
        checkValue("same_miss",       32'(MissCount), 32'd6);

        // Aliasing: 0x80 shares index 0 with 0x40
        update(32'h80, 1'b1, 32'h300);
        lookup(32'h40);
        checkValue("alias_40_hit",    32'(PredHit), 32'd0);
        checkValue("alias_40_target", PredTarget,   32'h44);
        lookup(32'h80);
        checkValue("alias_80_hit",    32'(PredHit), 32'd1);
        checkValue("alias_80_target", PredTarget,   32'h300);
        lookup(32'h82);
        checkValue("alias_82_hit",    32'(PredHit), 32'd1);
        checkValue("alias_miss",      32'(MissCount), 32'd7);

        // Invalidate wins over a simultaneous update, but the mispredict is counted
        Invalidate = 1'b1;
        update(32'h40, 1'b1, 32'h500);
        Invalidate = 1'b0;
        lookup(32'h40);
        checkValue("inv_40_hit",  32'(PredHit), 32'd0);
        lookup(32'h80);
        checkValue("inv_80_hit",  32'(PredHit), 32'd0);
        checkValue("inv_miss",    32'(MissCount), 32'd8);
        checkValue("inv_sat",     32'(satMissCount), 32'd3);

        // Asynchronous reset between edges
        update(32'h40, 1'b1, 32'h600);
        lookup(32'h40);
        checkValue("pre_rst_hit",  32'(PredHit), 32'd1);
        #2 Reset = 1'b1;
        #1;
        checkValue("arst_hit",    32'(PredHit),      32'd0);
        checkValue("arst_taken",  32'(PredTaken),    32'd0);
        checkValue("arst_target", PredTarget,        32'h44);
        checkValue("arst_miss",   32'(MissCount),    32'd0);
        checkValue("arst_sat",    32'(satMissCount), 32'd0);
        Reset = 1'b0;
        tick();
        checkValue("post_rst_hit", 32'(PredHit), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
